ps2_key_decoder: RTL and testbench

PS2_KEY_DECODER -- requirements
Module: ps2_key_decoder

---
 rtl/ps2_key_decoder.sv | 208 ++++++++++++++++++++
 tb/tb_ps2_key_decoder.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder
//   Pulls scan bytes from an upstream PS/2 keyboard FIFO and turns them into
//   key make/break events, a held-key tracker, a new-press counter and the
//   Shift/Ctrl/Caps Lock modifier state.
//
// Ports
//   clk         in   system clock, all state changes on the rising edge
//   clrn        in   asynchronous active-low reset
//   ready       in   upstream FIFO non-empty
//   data[7:0]   in   scan byte at the FIFO head
//   nextdata_n  out  active-low FIFO pop strobe, one cycle per consumed byte
//   key_code    out  code of the last make/break event
//   key_ext     out  last event was E0-prefixed
//   key_make    out  one-cycle pulse on a new key press
//   key_break   out  one-cycle pulse on a key release
//   key_held    out  a non-modifier key is currently held
//   press_cnt   out  count of new non-modifier presses (wraps mod 256)
//   shift       out  a Shift key (12h or 59h) is held
//   ctrl        out  a Ctrl key is held
//   caps        out  Caps Lock toggle state
module ps2_key_decoder #(
    parameter logic [7:0] CAPS_CODE = 8'h58,
    parameter logic [7:0] CTRL_CODE = 8'h14
) (
    input  logic       clk,
    input  logic       clrn,
    input  logic       ready,
    input  logic [7:0] data,
    output logic       nextdata_n,
    output logic [7:0] key_code,
    output logic       key_ext,
    output logic       key_make,
    output logic       key_break,
    output logic       key_held,
    output logic [7:0] press_cnt,
    output logic       shift,
    output logic       ctrl,
    output logic       caps
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        POP    = 2'd1,
        SETTLE = 2'd2
    } state_t;

    state_t     r_state,     w_state_nxt;
    logic [7:0] r_byte,      w_byte_nxt;
    logic       r_nextdata_n, w_nextdata_n_nxt;
    logic [7:0] r_key_code,  w_key_code_nxt;
    logic       r_key_ext,   w_key_ext_nxt;
    logic       r_key_make,  w_key_make_nxt;
    logic       r_key_break, w_key_break_nxt;
    logic       r_key_held,  w_key_held_nxt;
    logic [7:0] r_press_cnt, w_press_cnt_nxt;
    logic       r_shift,     w_shift_nxt;
    logic       r_ctrl,      w_ctrl_nxt;
    logic       r_caps,      w_caps_nxt;
    logic       r_ext_pend,  w_ext_pend_nxt;
    logic       r_brk_pend,  w_brk_pend_nxt;
    logic [7:0] r_held_code, w_held_code_nxt;
    logic       r_held_ext,  w_held_ext_nxt;

    logic w_is_shift;
    logic w_is_ctrl;
    logic w_is_repeat;

    assign w_is_shift  = (r_byte == 8'h12) || (r_byte == 8'h59);
    assign w_is_ctrl   = (r_byte == CTRL_CODE);
    // Typematic repeat: same code and same E0 qualifier as the held key.
    assign w_is_repeat = r_key_held && (r_byte == r_held_code) &&
                         (r_ext_pend == r_held_ext);

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_state      <= IDLE;
            r_byte       <= '0;
            r_nextdata_n <= 1'b1;
            r_key_code   <= '0;
            r_key_ext    <= 1'b0;
            r_key_make   <= 1'b0;
            r_key_break  <= 1'b0;
            r_key_held   <= 1'b0;
            r_press_cnt  <= '0;
            r_shift      <= 1'b0;
            r_ctrl       <= 1'b0;
            r_caps       <= 1'b0;
            r_ext_pend   <= 1'b0;
            r_brk_pend   <= 1'b0;
            r_held_code  <= '0;
            r_held_ext   <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_byte       <= w_byte_nxt;
            r_nextdata_n <= w_nextdata_n_nxt;
            r_key_code   <= w_key_code_nxt;
            r_key_ext    <= w_key_ext_nxt;
            r_key_make   <= w_key_make_nxt;
            r_key_break  <= w_key_break_nxt;
            r_key_held   <= w_key_held_nxt;
            r_press_cnt  <= w_press_cnt_nxt;
            r_shift      <= w_shift_nxt;
            r_ctrl       <= w_ctrl_nxt;
            r_caps       <= w_caps_nxt;
            r_ext_pend   <= w_ext_pend_nxt;
            r_brk_pend   <= w_brk_pend_nxt;
            r_held_code  <= w_held_code_nxt;
            r_held_ext   <= w_held_ext_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_byte_nxt       = r_byte;
        w_nextdata_n_nxt = r_nextdata_n;
        w_key_code_nxt   = r_key_code;
        w_key_ext_nxt    = r_key_ext;
        w_key_make_nxt   = 1'b0;
        w_key_break_nxt  = 1'b0;
        w_key_held_nxt   = r_key_held;
        w_press_cnt_nxt  = r_press_cnt;
        w_shift_nxt      = r_shift;
        w_ctrl_nxt       = r_ctrl;
        w_caps_nxt       = r_caps;
        w_ext_pend_nxt   = r_ext_pend;
        w_brk_pend_nxt   = r_brk_pend;
        w_held_code_nxt  = r_held_code;
        w_held_ext_nxt   = r_held_ext;

        unique case (r_state)
            IDLE: begin
                if (ready) begin
                    w_byte_nxt       = data;
                    w_nextdata_n_nxt = 1'b0;
                    w_state_nxt      = POP;
                end
            end

            POP: begin
                w_nextdata_n_nxt = 1'b1;
                w_state_nxt      = SETTLE;
                if (r_byte == 8'hE0) begin
                    w_ext_pend_nxt = 1'b1;
                end else if (r_byte == 8'hF0) begin
                    w_brk_pend_nxt = 1'b1;
                end else begin
                    w_ext_pend_nxt = 1'b0;
                    w_brk_pend_nxt = 1'b0;
                    if (r_brk_pend) begin
                        w_key_code_nxt  = r_byte;
                        w_key_ext_nxt   = r_ext_pend;
                        w_key_break_nxt = 1'b1;
                        if (r_key_held && (r_byte == r_held_code) &&
                            (r_ext_pend == r_held_ext)) begin
                            w_key_held_nxt = 1'b0;
                        end
                        if (w_is_shift) begin
                            w_shift_nxt = 1'b0;
                        end
                        if (w_is_ctrl) begin
                            w_ctrl_nxt = 1'b0;
                        end
                    end else if (w_is_shift || w_is_ctrl) begin
                        // Modifiers only update their own flag on make.
                        if (w_is_shift) begin
                            w_shift_nxt = 1'b1;
                        end
                        if (w_is_ctrl) begin
                            w_ctrl_nxt = 1'b1;
                        end
                    end else if (!w_is_repeat) begin
                        w_key_code_nxt  = r_byte;
                        w_key_ext_nxt   = r_ext_pend;
                        w_key_make_nxt  = 1'b1;
                        w_key_held_nxt  = 1'b1;
                        w_held_code_nxt = r_byte;
                        w_held_ext_nxt  = r_ext_pend;
                        w_press_cnt_nxt = r_press_cnt + 8'd1;
                        if (r_byte == CAPS_CODE) begin
                            w_caps_nxt = ~r_caps;
                        end
                    end
                end
            end

            SETTLE: begin
                // Gives the FIFO a cycle to advance before ready is looked at again.
                w_state_nxt = IDLE;
            end

            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign nextdata_n = r_nextdata_n;
    assign key_code   = r_key_code;
    assign key_ext    = r_key_ext;
    assign key_make   = r_key_make;
    assign key_break  = r_key_break;
    assign key_held   = r_key_held;
    assign press_cnt  = r_press_cnt;
    assign shift      = r_shift;
    assign ctrl       = r_ctrl;
    assign caps       = r_caps;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// tb_ps2_key_decoder
//   Scoreboard bench for ps2_key_decoder. The bench models the upstream FIFO
//   (ready/data driven from a byte queue, popped when nextdata_n is seen low)
//   and a reference model that turns each queued byte into the expected event.
//   A separate monitor compares every make/break pulse with the next entry.
module tb_ps2_key_decoder;

    localparam logic [7:0] CAPS = 8'h58;
    localparam logic [7:0] CTRL = 8'h14;

    logic       clk;
    logic       clrn;
    logic       ready;
    logic [7:0] data;
    logic       nextdata_n;
    logic [7:0] key_code;
    logic       key_ext;
    logic       key_make;
    logic       key_break;
    logic       key_held;
    logic [7:0] press_cnt;
    logic       shift;
    logic       ctrl;
    logic       caps;

    ps2_key_decoder #(.CAPS_CODE(CAPS), .CTRL_CODE(CTRL)) dut (
        .clk        (clk),
        .clrn       (clrn),
        .ready      (ready),
        .data       (data),
        .nextdata_n (nextdata_n),
        .key_code   (key_code),
        .key_ext    (key_ext),
        .key_make   (key_make),
        .key_break  (key_break),
        .key_held   (key_held),
        .press_cnt  (press_cnt),
        .shift      (shift),
        .ctrl       (ctrl),
        .caps       (caps)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       mk;
        logic [7:0] code;
        logic       ext;
        logic [7:0] cnt;
        logic       held;
        logic       shift;
        logic       ctrl;
        logic       caps;
    } ev_t;

    ev_t         exp_q[$];
    int unsigned rd_idx;
    logic [7:0]  fifo[$];
    int unsigned low_cycles[$];
    int unsigned cyc_main;
    int unsigned lows;
    int          checks;
    int          failures;

    // Reference model state
    bit         m_ext, m_brk, m_held, m_hext, m_shift, m_ctrl, m_caps;
    logic [7:0] m_hcode, m_cnt;

    logic [7:0] pool [12] = '{8'h1C, 8'h2A, 8'h75, 8'h12, 8'h59, 8'h14,
                              8'h58, 8'hE0, 8'hF0, 8'hF0, 8'h3B, 8'h1C};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, req, $time);
        end
    endtask

    task automatic model_reset();
        m_ext = 0; m_brk = 0; m_held = 0; m_hext = 0;
        m_shift = 0; m_ctrl = 0; m_caps = 0;
        m_hcode = '0; m_cnt = '0;
    endtask

    // Queue a byte to the FIFO and predict what it does.
    task automatic send(input logic [7:0] b);
        ev_t e;
        bit  emit;
        emit = 0;
        e.mk = 0;
        fifo.push_back(b);
        if (b == 8'hE0) begin
            m_ext = 1;
        end else if (b == 8'hF0) begin
            m_brk = 1;
        end else begin
            if (m_brk) begin
                if (m_held && m_hcode == b && m_hext == m_ext) m_held = 0;
                if (b == 8'h12 || b == 8'h59) m_shift = 0;
                if (b == CTRL) m_ctrl = 0;
                emit = 1;
                e.mk = 0;
            end else if (b == 8'h12 || b == 8'h59 || b == CTRL) begin
                if (b == CTRL) m_ctrl = 1;
                else m_shift = 1;
            end else if (!(m_held && m_hcode == b && m_hext == m_ext)) begin
                m_held = 1;
                m_hcode = b;
                m_hext = m_ext;
                m_cnt = m_cnt + 8'd1;
                if (b == CAPS) m_caps = !m_caps;
                emit = 1;
                e.mk = 1;
            end
            if (emit) begin
                e.code = b; e.ext = m_ext; e.cnt = m_cnt; e.held = m_held;
                e.shift = m_shift; e.ctrl = m_ctrl; e.caps = m_caps;
                exp_q.push_back(e);
            end
            m_ext = 0;
            m_brk = 0;
        end
    endtask

    // One cycle of the upstream FIFO model.
    task automatic tick();
        @(negedge clk);
        cyc_main++;
        if (clrn && !nextdata_n && fifo.size() != 0) begin
            void'(fifo.pop_front());
            lows++;
            low_cycles.push_back(cyc_main);
        end
        ready = (fifo.size() != 0);
        data  = ready ? fifo[0] : 8'($urandom);
    endtask

    task automatic check_state(input string tag);
        chk({tag, "_press_cnt"}, press_cnt, m_cnt);
        chk({tag, "_key_held"},  key_held,  m_held);
        chk({tag, "_shift"},     shift,     m_shift);
        chk({tag, "_ctrl"},      ctrl,      m_ctrl);
        chk({tag, "_caps"},      caps,      m_caps);
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (fifo.size() != 0 && n < 3000) begin
            tick();
            n++;
        end
        repeat (4) tick();
        chk({tag, "_drained"}, fifo.size(), 0);
        check_state(tag);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_nextdata_n"}, nextdata_n, 1);
        chk({tag, "_key_code"},   key_code,   0);
        chk({tag, "_key_ext"},    key_ext,    0);
        chk({tag, "_key_make"},   key_make,   0);
        chk({tag, "_key_break"},  key_break,  0);
        chk({tag, "_key_held"},   key_held,   0);
        chk({tag, "_press_cnt"},  press_cnt,  0);
        chk({tag, "_shift"},      shift,      0);
        chk({tag, "_ctrl"},       ctrl,       0);
        chk({tag, "_caps"},       caps,       0);
    endtask

    task automatic do_reset();
        clrn = 1'b0;
        fifo.delete();
        tick();
        tick();
        clrn = 1'b1;
        model_reset();
    endtask

    // Monitor: compares every event pulse with the scoreboard.
    initial begin
        ev_t         ev;
        int unsigned cyc_mon;
        int unsigned last_low;
        bit          prev_low;
        rd_idx   = 0;
        cyc_mon  = 0;
        last_low = 0;
        prev_low = 0;
        forever begin
            @(negedge clk);
            cyc_mon++;
            if (!clrn) begin
                prev_low = 0;
            end else begin
                if (!nextdata_n) begin
                    chk("nd_single_low", prev_low, 0);
                    last_low = cyc_mon;
                end
                prev_low = !nextdata_n;
                if (key_make || key_break) begin
                    chk("ev_not_both", key_make & key_break, 0);
                    chk("ev_expected", rd_idx < exp_q.size(), 1);
                    if (rd_idx < exp_q.size()) begin
                        ev = exp_q[rd_idx];
                        rd_idx++;
                        chk("ev_make",    key_make,  ev.mk);
                        chk("ev_break",   key_break, !ev.mk);
                        chk("ev_code",    key_code,  ev.code);
                        chk("ev_ext",     key_ext,   ev.ext);
                        chk("ev_cnt",     press_cnt, ev.cnt);
                        chk("ev_held",    key_held,  ev.held);
                        chk("ev_shift",   shift,     ev.shift);
                        chk("ev_ctrl",    ctrl,      ev.ctrl);
                        chk("ev_caps",    caps,      ev.caps);
                        chk("ev_latency", cyc_mon - last_low, 1);
                    end
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned l0;
        int unsigned s;
        bit          found;
        checks = 0; failures = 0; lows = 0; cyc_main = 0;
        clrn = 1'b0; ready = 1'b0; data = '0;
        model_reset();
        tick();
        check_zero("reset");
        tick();
        clrn = 1'b1;

        // Make then break of 1Ch, three pops
        l0 = lows;
        send(8'h1C); send(8'hF0); send(8'h1C);
        drain("mk_brk");
        chk("mk_brk_pops", lows - l0, 3);

        // Typematic repeats
        for (int i = 0; i < 5; i++) send(8'h1C);
        send(8'hF0); send(8'h1C);
        drain("typematic");

        // Extended key; plain break does not release an ext-held key
        send(8'hE0); send(8'h75); send(8'hF0); send(8'h75);
        drain("ext_plain_brk");
        send(8'hE0); send(8'hF0); send(8'h75);
        drain("ext_brk");

        // Shift and Ctrl
        send(8'h12); drain("shift_on");
        send(8'h1C); send(8'hF0); send(8'h12);
        drain("shift_off");
        send(CTRL); drain("ctrl_on");
        send(8'hF0); send(CTRL); drain("ctrl_off");

        // Caps Lock toggles, repeat does not toggle
        send(CAPS); send(CAPS); send(8'hF0); send(CAPS);
        drain("caps_1");
        send(CAPS); send(8'hF0); send(CAPS);
        drain("caps_2");

        // Last key wins
        send(8'h1C); send(8'h2A); send(8'h1C);
        drain("last_wins");

        // Reset during POP: byte discarded, E0 prefix lost
        send(8'hE0);
        drain("pre_rst");
        fifo.push_back(8'h1C);
        tick();
        found = 0;
        for (int i = 0; i < 6 && !found; i++) begin
            @(posedge clk);
            #1;
            if (!nextdata_n) found = 1;
        end
        chk("rst_pop_seen", found, 1);
        clrn = 1'b0;
        #1;
        check_zero("rst_pop");
        fifo.delete();
        tick();
        tick();
        clrn = 1'b1;
        model_reset();
        send(8'h75);
        drain("post_rst");
        chk("post_rst_ext", key_ext, 0);

        // 256 new makes wrap press_cnt
        do_reset();
        for (int i = 0; i < 256; i++) send((i % 2 == 0) ? 8'h1C : 8'h2A);
        drain("wrap");
        chk("wrap_zero", press_cnt, 8'h00);

        // Continuous ready: one pop every 3 cycles
        s = low_cycles.size();
        for (int i = 0; i < 9; i++) send((i % 2 == 0) ? 8'h3B : 8'h2A);
        drain("thru");
        chk("thru_pops", low_cycles.size() - s, 9);
        for (int unsigned i = s + 1; i < low_cycles.size(); i++)
            chk("thru_period", low_cycles[i] - low_cycles[i-1], 3);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            send(pool[$urandom_range(0, 11)]);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 6)) tick();
        end
        drain("random");

        repeat (5) tick();
        chk("sb_all_consumed", rd_idx, exp_q.size());
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
